// File: rtl/minsec_stop_pkg.sv
// Shared constants, FSM state type and BCD/ASCII helpers for the stopwatch UART reporter.
package minsec_stop_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int MSG_LEN = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Only the 7-bit centisecond count can exceed two decimal digits.
  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    logic [6:0] w_q;
    w_q = sat99(v) / 7'd10;
    return ASCII_ZERO + {1'b0, w_q};
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [6:0] v);
    logic [6:0] w_r;
    w_r = sat99(v) % 7'd10;
    return ASCII_ZERO + {1'b0, w_r};
  endfunction

endpackage

// File: rtl/minsec_stop_uart_tx_byte.sv
// 8N1 byte serialiser: a 10-bit frame shifter timed by a 0..DIV-1 baud counter.
module minsec_stop_uart_tx_byte #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       bit_done_last
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit;
  logic          r_active;
  logic          w_tick;

  assign w_tick = r_active && (r_cnt == CNT_LAST);

  // Ones shift in behind the stop bit, so the line idles high once the frame drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shift  <= '1;
      r_bit    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_cnt    <= '0;
      r_shift  <= {1'b1, data, 1'b0};
      r_bit    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_tick) begin
        r_cnt   <= '0;
        r_shift <= {1'b1, r_shift[9:1]};
        r_bit   <= r_bit + 4'd1;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign tx            = r_shift[0];
  assign bit_done_last = w_tick && (r_bit == 4'd9);

endmodule

// File: rtl/minsec_stop_uart_reporter.sv
// Sends a snapshot of the stopwatch as "MM:SS.CC\r\n" over an 8N1 UART.
//   state | meaning
//   IDLE  | line high, waiting for start (ignored while busy is still high)
//   LOAD  | present character idx to the byte shifter
//   SEND  | byte on the wire; advance idx or finish after the stop bit
//   FIN   | frame complete; done is registered out of this state
module minsec_stop_uart_reporter #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] min_count,
  input  logic [5:0] sec_count,
  input  logic [6:0] cs_count,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  import minsec_stop_pkg::*;

  localparam int         DIV      = CLK_HZ / BAUD;
  localparam logic [3:0] IDX_LAST = 4'(MSG_LEN - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_idx;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic [6:0] r_cs;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_load;
  logic       w_bit_done_last;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic [7:0] w_char;

  assign w_accept = (r_state == ST_IDLE) && start && !r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (w_bit_done_last) begin
          w_state_nxt = (r_idx == IDX_LAST) ? ST_FIN : ST_LOAD;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy stays high through the done cycle so a start there is dropped.
  always_comb begin
    w_load     = (r_state == ST_LOAD);
    w_busy_nxt = (w_state_nxt != ST_IDLE) || (r_state == ST_FIN);
    w_done_nxt = (r_state == ST_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_min  <= '0;
      r_sec  <= '0;
      r_cs   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_idx <= '0;
        r_min <= min_count;
        r_sec <= sec_count;
        r_cs  <= cs_count;
      end else if ((r_state == ST_SEND) && w_bit_done_last && (r_idx != IDX_LAST)) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  always_comb begin
    w_char = ASCII_LF;
    case (r_idx)
      4'd0:    w_char = ascii_tens({1'b0, r_min});
      4'd1:    w_char = ascii_ones({1'b0, r_min});
      4'd2:    w_char = ASCII_COLON;
      4'd3:    w_char = ascii_tens({1'b0, r_sec});
      4'd4:    w_char = ascii_ones({1'b0, r_sec});
      4'd5:    w_char = ASCII_DOT;
      4'd6:    w_char = ascii_tens(r_cs);
      4'd7:    w_char = ascii_ones(r_cs);
      4'd8:    w_char = ASCII_CR;
      default: w_char = ASCII_LF;
    endcase
  end

  minsec_stop_uart_tx_byte #(
    .DIV(DIV)
  ) u_tx_byte (
    .clk          (clk),
    .reset        (reset),
    .load         (w_load),
    .data         (w_char),
    .tx           (tx),
    .bit_done_last(w_bit_done_last)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/minsec_stop_uart_reporter.md
# minsec_stop_uart_reporter

Serialises the stopwatch's current minute/second/centisecond count as ASCII text on a UART TX line. Its role is the opposite of the button input path: the button path feeds user commands into the stopwatch, and this block carries the stopwatch state out to a host terminal. It sits beside the stopwatch core and the FND controller. It snapshots the counts on a one-cycle `start` pulse and sends the fixed 10-character frame "MM:SS.CC\r\n" in 8N1 format.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000, system clock frequency in Hz.
- `BAUD`, default 9600, line rate.
- Derived `DIV = CLK_HZ / BAUD`, integer truncation; 10416 at the defaults. `DIV` ≥ 2 is required.

Ports:
- `clk`, input, 1, system clock; every register uses the rising edge.
- `reset`, input, 1, asynchronous, active-high.
- `start`, input, 1, one-cycle request to send a frame.
- `min_count`, input, 6, minutes, binary.
- `sec_count`, input, 6, seconds, binary.
- `cs_count`, input, 7, centiseconds, binary.
- `tx`, output, 1, UART serial data; idle level is 1.
- `busy`, output, 1, high while a frame is in progress.
- `done`, output, 1, one-cycle pulse when a frame completes.

## Operation
- FSM states:
  - IDLE: `tx`=1, `busy`=0. `start`=1 captures the three counts into snapshot registers and moves to LOAD.
  - LOAD: selects character `idx` (0..9) and loads it into the byte shifter. Goes to SEND.
  - SEND: shifts out start bit 0, then data bits D0..D7 (LSB first), then stop bit 1.
    - After the stop bit, if `idx`<9: increment `idx` and return to LOAD.
    - If `idx`=9: go to FIN.
  - FIN: pulses `done`, returns to IDLE.
- Character map:
  - idx 0/1: minute tens/ones.
  - idx 2: ':' (0x3A).
  - idx 3/4: second tens/ones.
  - idx 5: '.' (0x2E).
  - idx 6/7: centisecond tens/ones.
  - idx 8: CR (0x0D).
  - idx 9: LF (0x0A).
- Digit conversion:
  - A snapshot value v > 99 saturates to 99. Only `cs_count` can reach this (7 bits).
  - tens = v / 10, ones = v % 10. Each ASCII digit = 0x30 + digit.
  - Conversion is combinational from the snapshot registers.
- Snapshot: the counts are sampled only in the IDLE→LOAD cycle. Later input changes do not affect the frame in flight.
- `start` is ignored while `busy`=1; there is no queueing. A `start` arriving in the same cycle as FIN is also ignored.
- Reset, at any time including mid-character:
  - `tx`=1, `busy`=0, `done`=0, `idx`=0, baud counter 0, snapshot registers 0, state IDLE.
  - The partial character is abandoned. No recovery frame is sent.

## Timing
- Cycle T: `start` is sampled high in IDLE.
- T+1: `busy`=1, FSM in LOAD, `tx` still 1.
- T+2: `tx` drives the start bit of character 0.
- Every bit, including start and stop, lasts exactly `DIV` clocks. It is timed by a baud counter that counts 0..DIV-1 and resets at each bit boundary.
- LOAD costs one idle-high clock between characters. That clock extends the preceding stop bit to `DIV`+1 clocks, which is legal for UART.
- Frame length:
  - 10 characters × 10 bits × `DIV` clocks, plus 10 LOAD cycles.
  - Last stop bit ends at T+1+10·(10·DIV+1).
  - FIN follows in the next cycle: `done`=1 and `busy`=1 in that cycle.
  - `busy`=0 in the cycle after that.
- Outputs `tx`, `busy` and `done` are registered, with no combinational path from the inputs.

## Structure
- Package `minsec_stop_pkg` holds:
  - ASCII constants `ASCII_ZERO`, `ASCII_COLON`, `ASCII_DOT`, `ASCII_CR`, `ASCII_LF`.
  - `MSG_LEN` = 10.
  - The FSM state enum.
- One sub-module, `minsec_stop_uart_tx_byte`:
  - Takes `DIV`.
  - Ports: `clk`, `reset`, `load`, `data[7:0]`, `tx`, `bit_done_last` (high for one cycle at the end of the stop bit).
  - Owns the baud counter and the 10-bit shift register.
- The top of this block holds the outer FSM, the `idx` counter, the snapshot registers and the character mux.

## Test plan
Benches run with `CLK_HZ`=1000 and `BAUD`=100, so `DIV`=10.

1. min=12, sec=34, cs=56, then `start`. A UART monitor decodes "12:34.56\r\n" (0x31 0x32 0x3A 0x33 0x34 0x2E 0x35 0x36 0x0D 0x0A). `done` pulses once, at T+1012.
2. min=0, sec=0, cs=127. The frame is "00:00.99\r\n", confirming saturation.
3. `start` issued, then `start` pulsed again mid-frame, and the inputs changed mid-frame. Exactly one frame is sent, carrying the original snapshot values.
4. Bit timing check: from the first `tx` falling edge, the line is sampled at (k+0.5)·10 clocks. The start bit is 0, data bits match LSB-first order, and the stop bit is 1.
5. `reset` asserted during bit 4 of character 3. `tx`=1 and `busy`=0 immediately, with no `done` pulse. A following `start` sends a complete frame containing the new snapshot.
6. `start` held high continuously. Frames are sent back-to-back, each separated by the IDLE and LOAD cycles. Every frame is complete and `done` pulses once per frame.
